// File: rtl/param_sequencer.sv
// Glitch-free parameter sequencer: shadows requested synth parameters, fades/ramps amplitude around commits.
// Optional FREQ_GLIDE_EN macro replaces the phase_inc step change with an exponential glide during RAMP.
module param_sequencer #(
    parameter logic [15:0] RAMP_STEP   = 16'h0100,
    parameter int          GLIDE_SHIFT = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        update_tick,
    input  logic        sample_strobe,
    input  logic [31:0] phase_inc_in,
    input  logic [15:0] amplitude_in,
    input  logic [1:0]  wave_select_in,
    input  logic [31:0] mod_phase_inc_in,
    input  logic [15:0] mod_depth_in,
    output logic [31:0] phase_inc_out,
    output logic [15:0] amplitude_out,
    output logic [1:0]  wave_select_out,
    output logic [31:0] mod_phase_inc_out,
    output logic [15:0] mod_depth_out,
    output logic        apply_tick,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PENDING  = 3'd1;
    localparam logic [2:0] ST_FADE_OUT = 3'd2;
    localparam logic [2:0] ST_APPLY    = 3'd3;
    localparam logic [2:0] ST_RAMP     = 3'd4;

    localparam logic [31:0] RST_PHASE_INC     = 32'd18898;
    localparam logic [1:0]  RST_WAVE_SELECT   = 2'b00;
    localparam logic [31:0] RST_MOD_PHASE_INC = 32'd215;
    localparam logic [15:0] RST_MOD_DEPTH     = 16'h0200;

    generate
        if (GLIDE_SHIFT < 1 || GLIDE_SHIFT > 31) begin : g_bad_glide_shift
            $error("param_sequencer: GLIDE_SHIFT must be in 1..31");
        end
    endgenerate

    logic [2:0]  state_r, state_nxt_s;
    logic [31:0] sh_phase_inc_r, sh_mod_phase_inc_r;
    logic [15:0] sh_amplitude_r, sh_mod_depth_r;
    logic [1:0]  sh_wave_select_r;
    logic [31:0] phase_inc_r, mod_phase_inc_r, phase_inc_nxt_s;
    logic [15:0] amplitude_r, mod_depth_r, amp_nxt_s;
    logic [1:0]  wave_select_r;
    logic        apply_tick_r, busy_r;
    logic        phase_done_s;

    // An update landing in the APPLY cycle is committed directly, so outputs never lag the shadow
    logic [1:0]  sh_wave_nxt_s;
    logic [31:0] sh_mod_phase_nxt_s;
    logic [15:0] sh_mod_depth_nxt_s;
    assign sh_wave_nxt_s      = update_tick ? wave_select_in   : sh_wave_select_r;
    assign sh_mod_phase_nxt_s = update_tick ? mod_phase_inc_in : sh_mod_phase_inc_r;
    assign sh_mod_depth_nxt_s = update_tick ? mod_depth_in     : sh_mod_depth_r;

`ifdef FREQ_GLIDE_EN
    logic signed [32:0] pi_diff_s, pi_step_s, pi_sum_s;
    logic        [32:0] pi_mag_s;

    // Exponential glide of phase_inc toward the shadow target, one step per strobe in RAMP
    always_comb begin
        pi_diff_s       = $signed({1'b0, sh_phase_inc_r}) - $signed({1'b0, phase_inc_r});
        pi_mag_s        = pi_diff_s[32] ? 33'(-pi_diff_s) : 33'(pi_diff_s);
        pi_step_s       = pi_diff_s >>> GLIDE_SHIFT;
        pi_sum_s        = $signed({1'b0, phase_inc_r}) + pi_step_s;
        phase_inc_nxt_s = phase_inc_r;
        if (state_r == ST_RAMP && sample_strobe) begin
            if (pi_mag_s < (33'd1 << GLIDE_SHIFT)) begin
                phase_inc_nxt_s = sh_phase_inc_r;
            end else begin
                phase_inc_nxt_s = pi_sum_s[31:0];
            end
        end else begin
            phase_inc_nxt_s = phase_inc_r;
        end
    end
    assign phase_done_s = (phase_inc_r == sh_phase_inc_r);
`else
    logic [31:0] sh_phase_nxt_s;
    assign sh_phase_nxt_s = update_tick ? phase_inc_in : sh_phase_inc_r;

    // Step change of phase_inc at commit time
    always_comb begin
        if (state_r == ST_APPLY) begin
            phase_inc_nxt_s = sh_phase_nxt_s;
        end else begin
            phase_inc_nxt_s = phase_inc_r;
        end
    end
    assign phase_done_s = 1'b1;
`endif

    // Amplitude fade toward zero or ramp toward shadow, saturating and snapping within one step
    always_comb begin
        amp_nxt_s = amplitude_r;
        case (state_r)
            ST_FADE_OUT: begin
                if (sample_strobe) begin
                    amp_nxt_s = (amplitude_r > RAMP_STEP) ? amplitude_r - RAMP_STEP : 16'h0000;
                end else begin
                    amp_nxt_s = amplitude_r;
                end
            end
            ST_RAMP: begin
                if (!sample_strobe) begin
                    amp_nxt_s = amplitude_r;
                end else if (amplitude_r < sh_amplitude_r) begin
                    amp_nxt_s = (sh_amplitude_r - amplitude_r <= RAMP_STEP) ? sh_amplitude_r
                                                                            : amplitude_r + RAMP_STEP;
                end else if (amplitude_r > sh_amplitude_r) begin
                    amp_nxt_s = (amplitude_r - sh_amplitude_r <= RAMP_STEP) ? sh_amplitude_r
                                                                            : amplitude_r - RAMP_STEP;
                end else begin
                    amp_nxt_s = amplitude_r;
                end
            end
            default: amp_nxt_s = amplitude_r;
        endcase
    end

    // Sequencer next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (update_tick) state_nxt_s = ST_PENDING;
                else             state_nxt_s = ST_IDLE;
            end
            ST_PENDING: begin
                if (update_tick)         state_nxt_s = ST_PENDING;
                else if (!sample_strobe) state_nxt_s = ST_PENDING;
                else if (sh_wave_select_r != wave_select_r) state_nxt_s = ST_FADE_OUT;
                else                     state_nxt_s = ST_APPLY;
            end
            ST_FADE_OUT: begin
                if (amplitude_r == 16'h0000) state_nxt_s = ST_APPLY;
                else                         state_nxt_s = ST_FADE_OUT;
            end
            ST_APPLY: state_nxt_s = ST_RAMP;
            ST_RAMP: begin
                if (update_tick) state_nxt_s = ST_PENDING;
                else if (amplitude_r == sh_amplitude_r && phase_done_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_RAMP;
            end
            default: state_nxt_s = ST_PENDING;
        endcase
    end

    // State, shadow set and registered outputs; reset triggers a soft-start ramp to full volume
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r            <= ST_PENDING;
            busy_r             <= 1'b1;
            apply_tick_r       <= 1'b0;
            sh_phase_inc_r     <= RST_PHASE_INC;
            sh_amplitude_r     <= 16'hFFFF;
            sh_wave_select_r   <= RST_WAVE_SELECT;
            sh_mod_phase_inc_r <= RST_MOD_PHASE_INC;
            sh_mod_depth_r     <= RST_MOD_DEPTH;
            phase_inc_r        <= RST_PHASE_INC;
            amplitude_r        <= 16'h0000;
            wave_select_r      <= RST_WAVE_SELECT;
            mod_phase_inc_r    <= RST_MOD_PHASE_INC;
            mod_depth_r        <= RST_MOD_DEPTH;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            apply_tick_r <= (state_nxt_s == ST_APPLY);
            if (update_tick) begin
                sh_phase_inc_r     <= phase_inc_in;
                sh_amplitude_r     <= amplitude_in;
                sh_wave_select_r   <= wave_select_in;
                sh_mod_phase_inc_r <= mod_phase_inc_in;
                sh_mod_depth_r     <= mod_depth_in;
            end
            phase_inc_r <= phase_inc_nxt_s;
            amplitude_r <= amp_nxt_s;
            if (state_r == ST_APPLY) begin
                wave_select_r   <= sh_wave_nxt_s;
                mod_phase_inc_r <= sh_mod_phase_nxt_s;
                mod_depth_r     <= sh_mod_depth_nxt_s;
            end
        end
    end

    assign phase_inc_out     = phase_inc_r;
    assign amplitude_out     = amplitude_r;
    assign wave_select_out   = wave_select_r;
    assign mod_phase_inc_out = mod_phase_inc_r;
    assign mod_depth_out     = mod_depth_r;
    assign apply_tick        = apply_tick_r;
    assign busy              = busy_r;

endmodule

// File: doc/param_sequencer.md
PARAM_SEQUENCER -- requirements
Module: param_sequencer

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 16'h0100: amplitude change per sample strobe.
REQ-002 SHALL have parameter GLIDE_SHIFT, default 6: frequency glide divisor exponent (used only under FREQ_GLIDE_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port update_tick  input  1  one-cycle pulse: new parameter set valid on the *_in ports.
REQ-006 SHALL have port sample_strobe  input  1  one-cycle pulse at the audio sample rate.
REQ-007 SHALL have ports phase_inc_in  input  32, amplitude_in  input  16, wave_select_in  input  2, mod_phase_inc_in  input  32, mod_depth_in  input  16: requested parameters.
REQ-008 SHALL have ports phase_inc_out  output  32, amplitude_out  output  16, wave_select_out  output  2, mod_phase_inc_out  output  32, mod_depth_out  output  16: applied parameters to the synthesis datapath.
REQ-009 SHALL have port apply_tick  output  1  one-cycle pulse when the shadow set is committed.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL hold a shadow register set (all five parameters), loaded from *_in on every update_tick in any state.
REQ-012 SHALL implement states IDLE, PENDING, FADE_OUT, APPLY, RAMP.
REQ-013 IDLE: update_tick -> PENDING; otherwise outputs hold.
REQ-014 PENDING: on sample_strobe without update_tick, go to FADE_OUT if shadow wave_select differs from wave_select_out, else APPLY; strobe coincident with update_tick SHALL be ignored (stay PENDING, new shadow).
REQ-015 FADE_OUT: each sample_strobe SHALL decrement amplitude_out by RAMP_STEP, saturating at 0; when amplitude_out is 0 -> APPLY; update_tick stays in FADE_OUT.
REQ-016 APPLY: exactly one cycle; SHALL copy shadow wave_select, mod_phase_inc, mod_depth (and phase_inc when glide disabled) to outputs, pulse apply_tick, -> RAMP.
REQ-017 RAMP: each sample_strobe SHALL move amplitude_out toward shadow amplitude by RAMP_STEP, snapping to target when |difference| <= RAMP_STEP; no overflow or undershoot.
REQ-018 RAMP exit: when all ramped outputs equal shadow -> IDLE; update_tick in RAMP -> PENDING.
REQ-019 Arithmetic SHALL be unsigned, full width, no wrap-around on amplitude or phase_inc.
REQ-020 apply_tick SHALL be low in all states except APPLY.

Reset
REQ-021 Reset SHALL force: phase_inc_out 32'd18898, amplitude_out 16'h0000, wave_select_out 2'b00, mod_phase_inc_out 32'd215, mod_depth_out 16'h0200, apply_tick 0.
REQ-022 Reset SHALL load shadow with the same values except amplitude 16'hFFFF and enter PENDING (soft start ramp to full volume, busy=1).
REQ-023 Reset asserted mid-ramp or mid-fade SHALL abort immediately to the REQ-021/022 state.

Configuration
REQ-024 Macro FREQ_GLIDE_EN: when defined, APPLY SHALL not copy phase_inc; in RAMP each sample_strobe phase_inc_out SHALL add signed (shadow - out) >>> GLIDE_SHIFT, snapping to target when |difference| < 2^GLIDE_SHIFT; RAMP exit requires phase_inc_out equal to shadow too.
REQ-025 Without FREQ_GLIDE_EN, phase_inc_out SHALL change only in APPLY (step change), and no glide logic SHALL be synthesised.

Verification
REQ-026 Release reset, strobe every 16 clks -> first strobe moves to APPLY, apply_tick once, amplitude_out reaches 16'hFFFF after 256 RAMP strobes, then busy=0.
REQ-027 In IDLE, update_tick with wave_select_in=2'b01, amplitude 16'hFFFF -> FADE_OUT to 0 in 256 strobes, wave_select_out changes only in APPLY cycle, ramp back to 16'hFFFF.
REQ-028 update_tick and sample_strobe same cycle in PENDING -> state stays PENDING, commit occurs on next strobe with the newer values.
REQ-029 amplitude_in 16'h0050 from 16'hFFFF, same wave -> RAMP decrements by 16'h0100, final step snaps to 16'h0050, no underflow.
REQ-030 FREQ_GLIDE_EN defined, phase_inc 18898 -> 37796 -> phase_inc_out increases monotonically per strobe, ends exactly 37796; without macro it steps in the APPLY cycle.
REQ-031 reset_n low mid-FADE_OUT -> outputs immediately at REQ-021 values, no apply_tick.
